// File: rtl/bmem_line_arbiter.sv
// Arbitrates i-cache / d-cache line misses onto one 64-bit burst-memory port.
// Optional build macro BMEM_ARB_PERF_EN adds saturating grant/conflict counters.
module bmem_line_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic              ic_read,
  output logic [LINE_W-1:0] ic_rdata,
  output logic              ic_resp,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              dc_resp,
  output logic [ADDR_W-1:0] bmem_address,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_resp
`ifdef BMEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_ic_reqs,
  output logic [31:0]       perf_dc_reqs,
  output logic [31:0]       perf_conflicts
`endif
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam logic [ADDR_W-1:0] LINE_OFS_MASK = ADDR_W'(LINE_W / 8 - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_ISSUE = 3'd1;
  localparam logic [2:0] RD_BEATS = 3'd2;
  localparam logic [2:0] WR_BEATS = 3'd3;
  localparam logic [2:0] WR_ACK   = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  logic [2:0]        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [1:0]        beat_cnt_reg;
  logic              grant_dc_reg;
  logic              last_grant_reg;  // 1: d-cache was granted last
  logic              hold_reg;        // blocks grants in the cycle after DONE
  logic [LINE_W-1:0] line_buf_reg;
  logic [LINE_W-1:0] ic_rdata_reg;
  logic [LINE_W-1:0] dc_rdata_reg;

  logic              ic_pend, dc_pend;
  logic              grant_valid, grant_dc;
  logic [ADDR_W-1:0] sel_addr;
  logic [LINE_W-1:0] line_fill;
  logic [BEAT_W-1:0] wr_beat [BEATS];

  assign ic_pend     = ic_read;
  assign dc_pend     = dc_read | dc_write;
  assign grant_valid = (state_reg == IDLE) && !hold_reg && (ic_pend || dc_pend);
  assign grant_dc    = dc_pend && (!ic_pend || !last_grant_reg);
  assign sel_addr    = grant_dc ? dc_addr : ic_addr;

  // line_fill is the buffer with the current beat slot replaced by incoming data
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
    assign line_fill[gi*BEAT_W +: BEAT_W] = (beat_cnt_reg == 2'(gi)) ? bmem_rdata
                                          : line_buf_reg[gi*BEAT_W +: BEAT_W];
    assign wr_beat[gi] = dc_wdata[gi*BEAT_W +: BEAT_W];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (grant_valid) state_next = (grant_dc && dc_write) ? WR_BEATS : RD_ISSUE;
      RD_ISSUE: state_next = RD_BEATS;
      RD_BEATS: if (bmem_resp && beat_cnt_reg == 2'd3) state_next = DONE;
      WR_BEATS: if (beat_cnt_reg == 2'd3) state_next = WR_ACK;
      WR_ACK:   if (bmem_resp) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      beat_cnt_reg   <= '0;
      grant_dc_reg   <= 1'b0;
      last_grant_reg <= 1'b0;
      hold_reg       <= 1'b0;
      line_buf_reg   <= '0;
      ic_rdata_reg   <= '0;
      dc_rdata_reg   <= '0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= (state_reg == DONE);
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            grant_dc_reg   <= grant_dc;
            last_grant_reg <= grant_dc;
            addr_reg       <= sel_addr & ~LINE_OFS_MASK;
          end
        end
        RD_BEATS: begin
          if (bmem_resp) begin
            line_buf_reg <= line_fill;
            beat_cnt_reg <= beat_cnt_reg + 2'd1;
            if (beat_cnt_reg == 2'd3) begin
              if (grant_dc_reg) dc_rdata_reg <= line_fill;
              else              ic_rdata_reg <= line_fill;
            end
          end
        end
        WR_BEATS: beat_cnt_reg <= beat_cnt_reg + 2'd1;
        default: ;
      endcase
    end
  end

  assign bmem_address = addr_reg;
  assign bmem_read    = (state_reg == RD_ISSUE);
  assign bmem_write   = (state_reg == WR_BEATS);
  assign bmem_wdata   = (state_reg == WR_BEATS) ? wr_beat[beat_cnt_reg] : '0;
  assign ic_resp      = (state_reg == DONE) && !grant_dc_reg;
  assign dc_resp      = (state_reg == DONE) && grant_dc_reg;
  assign ic_rdata     = ic_rdata_reg;
  assign dc_rdata     = dc_rdata_reg;

`ifdef BMEM_ARB_PERF_EN
  logic [31:0] perf_ic_reqs_reg, perf_dc_reqs_reg, perf_conflicts_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_ic_reqs_reg   <= '0;
      perf_dc_reqs_reg   <= '0;
      perf_conflicts_reg <= '0;
    end else begin
      if (grant_valid && !grant_dc && perf_ic_reqs_reg != '1)
        perf_ic_reqs_reg <= perf_ic_reqs_reg + 32'd1;
      if (grant_valid && grant_dc && perf_dc_reqs_reg != '1)
        perf_dc_reqs_reg <= perf_dc_reqs_reg + 32'd1;
      if (state_reg == IDLE && ic_pend && dc_pend && perf_conflicts_reg != '1)
        perf_conflicts_reg <= perf_conflicts_reg + 32'd1;
    end
  end

  assign perf_ic_reqs   = perf_ic_reqs_reg;
  assign perf_dc_reqs   = perf_dc_reqs_reg;
  assign perf_conflicts = perf_conflicts_reg;
`endif

endmodule
